fft_seq_ctrl: RTL and testbench
===============================

// Module: fft_seq_ctrl
// PURPOSE
//  Sequencer for the in-place radix-2 DIT FFT engine built on fft_pkg complex_t butterflies. Runs one frame
//  through LOAD (bit-reversed write of N input samples), CALC (log2N stages of N/2 butterfly issues, with
//  twiddle index and delayed write-back addresses) and UNLOAD (natural-order read-out with valid/ready).
//  Owns no sample data; drives the sample RAM, twiddle ROM and butterfly pipe around it.
// PARAMETERS
//  N_LOG2    8  log2 of FFT length N (3..12)
//  PIPE_LAT  3  butterfly issue->write-back latency in cycles (>=1)
// PORTS
//  clk_i        in   1        clock
//  rst_ni       in   1        synchronous active-low reset
//  start_i      in   1        begin a frame (sampled in IDLE only)
//  busy_o       out  1        high in any state except IDLE
//  done_o       out  1        1-cycle pulse after last UNLOAD handshake
//  in_valid_i   in   1        input sample valid
//  in_ready_o   out  1        high in LOAD
//  mem_we_o     out  1        LOAD write strobe (= in_valid_i & in_ready_o)
//  mem_waddr_o  out  N_LOG2   bit-reversed input index
//  bf_issue_o   out  1        butterfly read/issue strobe
//  bf_addr_a_o  out  N_LOG2   upper-leg address
//  bf_addr_b_o  out  N_LOG2   lower-leg address (a + span)
//  tw_idx_o     out  N_LOG2-1 twiddle ROM index
//  stage_o      out  N_LOG2'  current stage, width $clog2(N_LOG2)
//  wb_we_o      out  1        write-back strobe, bf_issue_o delayed PIPE_LAT cycles
//  wb_addr_a_o  out  N_LOG2   bf_addr_a_o delayed PIPE_LAT cycles
//  wb_addr_b_o  out  N_LOG2   bf_addr_b_o delayed PIPE_LAT cycles
//  mem_re_o     out  1        UNLOAD read enable; RAM output register holds when low
//  mem_raddr_o  out  N_LOG2   natural-order read index
//  out_valid_o  out  1        RAM read data valid (1-cycle read latency)
//  out_ready_i  in   1        downstream ready
// BEHAVIOUR
//  - Reset (rst_ni=0 at edge): state IDLE; all counters 0; every output 0; delay line cleared. Mid-frame
//    reset aborts immediately, no done_o.
//  - FSM: IDLE -start_i-> LOAD -N-th write-> CALC -last stage drained-> UNLOAD -N-th out handshake-> IDLE.
//    start_i while busy_o is ignored.
//  - LOAD: counter i counts in handshakes; mem_waddr_o = bitrev(i). Last write moves to CALC next cycle.
//  - CALC: per stage s, j = 0..N/2-1, one issue per cycle, no stall input. span=1<<s, k=j&(span-1),
//    a=((j>>s)<<(s+1))|k, b=a+span, tw=k<<(N_LOG2-1-s). After j=N/2-1, bf_issue_o low for PIPE_LAT cycles
//    (drain barrier, RAW safety), then s+1 begins. Total CALC cycles = N_LOG2*(N/2+PIPE_LAT). wb_* come from
//    a PIPE_LAT-deep register delay line that keeps shifting during the drain; the last write-back of the
//    last stage lands in the final CALC cycle.
//  - UNLOAD: mem_re_o = !out_valid_o | out_ready_i while reads remain; raddr increments per read.
//    out_valid_o set cycle after a read, cleared on handshake with no new read. Full throughput under
//    ready=1. On the N-th handshake: done_o=1 next cycle, state IDLE.
//  - All address arithmetic unsigned, modulo N; counters wrap to 0 on frame end.
// CONFIGURATION
//  FFT_INV_EN defined: adds ports inv_i (in,1) and tw_conj_o (out,1). inv_i is latched on the IDLE->LOAD
//    transition. tw_conj_o = latched value whenever bf_issue_o=1, else 0. Reset clears it.
//  FFT_INV_EN undefined: neither port exists; forward transform only.
// TESTING (N_LOG2=3, PIPE_LAT=3)
//  - Load: start, 8 inputs, valid=1 -> mem_waddr_o = 0,4,2,6,1,5,3,7; in_ready_o drops after the 8th.
//  - Stage addresses: (a,b,tw) s0=(0,1,0)(2,3,0)(4,5,0)(6,7,0); s1=(0,2,0)(1,3,2)(4,6,0)(5,7,2);
//    s2=(0,4,0)(1,5,1)(2,6,2)(3,7,3); 3 idle cycles between stages; CALC = 21 cycles.
//  - Write-back: each wb_we_o/wb_addr pair appears exactly 3 cycles after the matching issue.
//  - Unload: ready toggles 1,0,1,... -> out order 0..7, no drops/dups, done_o 1 cycle after 8th handshake.
//  - Robustness: start_i pulsed during CALC is ignored. rst_ni=0 in stage 1 -> next cycle IDLE, outputs 0.
//  - FFT_INV_EN: inv_i=1 at start -> tw_conj_o=1 on all 12 issues; inv_i=0 -> tw_conj_o stays 0.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - LOAD/CALC/UNLOAD sequencer for an in-place radix-2 DIT FFT engine
// Optional macro FFT_INV_EN adds inv_i / tw_conj_o for inverse transforms.
module fft_seq_ctrl #(
  parameter int N_LOG2   = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic                        mem_we_o,
  output logic [N_LOG2-1:0]           mem_waddr_o,
  output logic                        bf_issue_o,
  output logic [N_LOG2-1:0]           bf_addr_a_o,
  output logic [N_LOG2-1:0]           bf_addr_b_o,
  output logic [N_LOG2-2:0]           tw_idx_o,
  output logic [$clog2(N_LOG2)-1:0]   stage_o,
  output logic                        wb_we_o,
  output logic [N_LOG2-1:0]           wb_addr_a_o,
  output logic [N_LOG2-1:0]           wb_addr_b_o,
`ifdef FFT_INV_EN
  input  logic                        inv_i,
  output logic                        tw_conj_o,
`endif
  output logic                        mem_re_o,
  output logic [N_LOG2-1:0]           mem_raddr_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i
);

  localparam int SW = $clog2(N_LOG2);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int N  = 1 << N_LOG2;

  localparam logic [N_LOG2-1:0] ONE        = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] IDX_LAST   = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] J_LAST     = N_LOG2'(N / 2 - 1);
  localparam logic [SW-1:0]     STAGE_LAST = SW'(N_LOG2 - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CALC   = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  logic [1:0]        r_state;
  logic [N_LOG2-1:0] r_idx;       // load index, butterfly j, or read address depending on state
  logic [SW-1:0]     r_stage;
  logic              r_draining;
  logic [DW-1:0]     r_drain;
  logic              r_rd_done;
  logic [N_LOG2-1:0] r_out_cnt;
  logic              r_out_valid;
  logic              r_done;

  logic [PIPE_LAT-1:0] r_wb_we;
  logic [N_LOG2-1:0]   r_wb_a [PIPE_LAT];
  logic [N_LOG2-1:0]   r_wb_b [PIPE_LAT];

  logic              w_load, w_calc, w_unload, w_issue, w_hs;
  logic [N_LOG2-1:0] w_bitrev, w_span, w_mask, w_a, w_b;
  logic [N_LOG2-2:0] w_k, w_tw;

  assign w_load   = (r_state == S_LOAD);
  assign w_calc   = (r_state == S_CALC);
  assign w_unload = (r_state == S_UNLOAD);

  always_comb begin
    w_bitrev = '0;
    for (int i = 0; i < N_LOG2; i++) w_bitrev[i] = r_idx[N_LOG2-1-i];
  end

  // Butterfly pair: insert a zero at bit s of j to get a; b sets that bit.
  assign w_issue = w_calc & ~r_draining;
  assign w_span  = ONE << r_stage;
  assign w_mask  = w_span - ONE;
  assign w_k     = r_idx[N_LOG2-2:0] & w_mask[N_LOG2-2:0];
  assign w_a     = ((r_idx & ~w_mask) << 1) | {1'b0, w_k};
  assign w_b     = w_a + w_span;
  assign w_tw    = w_k << (STAGE_LAST - r_stage);

  assign w_hs    = r_out_valid & out_ready_i;

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign in_ready_o  = w_load;
  assign mem_we_o    = in_valid_i & w_load;
  assign mem_waddr_o = w_load ? w_bitrev : '0;
  assign bf_issue_o  = w_issue;
  assign bf_addr_a_o = w_issue ? w_a : '0;
  assign bf_addr_b_o = w_issue ? w_b : '0;
  assign tw_idx_o    = w_issue ? w_tw : '0;
  assign stage_o     = r_stage;
  assign wb_we_o     = r_wb_we[PIPE_LAT-1];
  assign wb_addr_a_o = r_wb_a[PIPE_LAT-1];
  assign wb_addr_b_o = r_wb_b[PIPE_LAT-1];
  assign mem_re_o    = w_unload & ~r_rd_done & (~r_out_valid | out_ready_i);
  assign mem_raddr_o = w_unload ? r_idx : '0;
  assign out_valid_o = r_out_valid;

`ifdef FFT_INV_EN
  logic r_inv;
  assign tw_conj_o = r_inv & w_issue;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_stage     <= '0;
      r_draining  <= 1'b0;
      r_drain     <= '0;
      r_rd_done   <= 1'b0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef FFT_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_LOAD;
`ifdef FFT_INV_EN
            r_inv   <= inv_i;
`endif
          end
        end
        S_LOAD: begin
          if (mem_we_o) begin
            r_idx <= r_idx + ONE;
            if (r_idx == IDX_LAST) r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!r_draining) begin
            if (r_idx == J_LAST) begin
              r_idx      <= '0;
              r_draining <= 1'b1;
            end else begin
              r_idx <= r_idx + ONE;
            end
          end else if (r_drain == DRAIN_LAST) begin
            // Pipe is empty: the next stage may read what this one wrote.
            r_drain    <= '0;
            r_draining <= 1'b0;
            if (r_stage == STAGE_LAST) begin
              r_stage <= '0;
              r_state <= S_UNLOAD;
            end else begin
              r_stage <= r_stage + SW'(1);
            end
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_UNLOAD: begin
          if (mem_re_o) begin
            r_idx       <= r_idx + ONE;
            r_out_valid <= 1'b1;
            if (r_idx == IDX_LAST) r_rd_done <= 1'b1;
          end else if (w_hs) begin
            r_out_valid <= 1'b0;
          end
          if (w_hs) begin
            r_out_cnt <= r_out_cnt + ONE;
            if (r_out_cnt == IDX_LAST) begin
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
              r_rd_done <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wb_we <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_wb_a[i] <= '0;
        r_wb_b[i] <= '0;
      end
    end else begin
      r_wb_we[0] <= w_issue;
      r_wb_a[0]  <= bf_addr_a_o;
      r_wb_b[0]  <= bf_addr_b_o;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_wb_we[i] <= r_wb_we[i-1];
        r_wb_a[i]  <= r_wb_a[i-1];
        r_wb_b[i]  <= r_wb_b[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - self-checking bench for fft_seq_ctrl (N_LOG2=3, PIPE_LAT=3)
module tb_fft_seq_ctrl;

  localparam int NL = 3;
  localparam int PL = 3;
  localparam int N  = 8;
  localparam int CALC_CYC = NL * (N / 2 + PL);

  logic       clk_i = 1'b0;
  logic       rst_ni, start_i, in_valid_i, out_ready_i;
  logic       busy_o, done_o, in_ready_o, mem_we_o, bf_issue_o, wb_we_o, mem_re_o, out_valid_o;
  logic [2:0] mem_waddr_o, bf_addr_a_o, bf_addr_b_o, wb_addr_a_o, wb_addr_b_o, mem_raddr_o;
  logic [1:0] tw_idx_o, stage_o;
  logic [2:0] ram_q;
`ifdef FFT_INV_EN
  logic       inv_i, tw_conj_o;
`endif

  int errors = 0;
  int checks = 0;

  int waddr_tbl [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int a_tbl     [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int b_tbl     [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tw_tbl    [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_seq_ctrl #(.N_LOG2(NL), .PIPE_LAT(PL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .bf_issue_o(bf_issue_o), .bf_addr_a_o(bf_addr_a_o), .bf_addr_b_o(bf_addr_b_o),
    .tw_idx_o(tw_idx_o), .stage_o(stage_o), .wb_we_o(wb_we_o), .wb_addr_a_o(wb_addr_a_o),
    .wb_addr_b_o(wb_addr_b_o),
`ifdef FFT_INV_EN
    .inv_i(inv_i), .tw_conj_o(tw_conj_o),
`endif
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Sample RAM stand-in: each word holds its own address, so read order is visible.
  always @(posedge clk_i) if (mem_re_o) ram_q <= mem_raddr_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < NL; b++) if ((v >> b) & 1) r += 1 << (NL - 1 - b);
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_issue"}, bf_issue_o, 0);
    chk({tag, "_wb_we"}, wb_we_o, 0);
    chk({tag, "_wb_a"}, wb_addr_a_o, 0);
    chk({tag, "_stage"}, stage_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_mem_re"}, mem_re_o, 0);
  endtask

  task automatic run_frame(input bit directed, input bit inv, input int abort_at);
    int cnt, cyc, s, p, q, rd, hs;
    bit ev, er, iss, wbe;
    start_i = 1'b1;
`ifdef FFT_INV_EN
    inv_i = inv;
`endif
    @(negedge clk_i);
    start_i = 1'b0;
`ifdef FFT_INV_EN
    inv_i = ~inv;
`endif
    cnt = 0;
    cyc = 0;
    while (cnt < N && cyc < 200) begin
      in_valid_i = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      chk("load_ready", in_ready_o, 1);
      chk("load_we", mem_we_o, in_valid_i);
      if (in_valid_i) begin
        chk("load_waddr", mem_waddr_o, brev(cnt));
        if (directed) chk("load_waddr_tbl", mem_waddr_o, waddr_tbl[cnt]);
        cnt++;
      end
      @(negedge clk_i);
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("load_count", cnt, N);

    for (int c = 0; c < CALC_CYC; c++) begin
      if (c == abort_at) begin
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_quiet("abort");
        @(negedge clk_i);
        chk("abort_no_done", done_o, 0);
        chk("abort_idle", busy_o, 0);
        return;
      end
      start_i = (c == 5);
      s = c / (N / 2 + PL);
      p = c % (N / 2 + PL);
      iss = (p < N / 2);
      q = c - PL;
      wbe = (q >= 0) && ((q % (N / 2 + PL)) < N / 2);
      #1;
      chk("calc_busy", busy_o, 1);
      chk("calc_in_ready", in_ready_o, 0);
      chk("calc_issue", bf_issue_o, iss);
      chk("calc_stage", stage_o, s);
      if (iss) begin
        chk("calc_a", bf_addr_a_o, a_tbl[s * 4 + p]);
        chk("calc_b", bf_addr_b_o, b_tbl[s * 4 + p]);
        chk("calc_tw", tw_idx_o, tw_tbl[s * 4 + p]);
      end
`ifdef FFT_INV_EN
      chk("calc_conj", tw_conj_o, inv & iss);
`endif
      chk("wb_we", wb_we_o, wbe);
      if (wbe) begin
        chk("wb_a", wb_addr_a_o, a_tbl[(q / 7) * 4 + q % 7]);
        chk("wb_b", wb_addr_b_o, b_tbl[(q / 7) * 4 + q % 7]);
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;

    rd = 0;
    hs = 0;
    ev = 1'b0;
    cyc = 0;
    while (hs < N && cyc < 200) begin
      out_ready_i = directed ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      #1;
      er = (rd < N) && (!ev || out_ready_i);
      chk("unl_busy", busy_o, 1);
      chk("unl_done_low", done_o, 0);
      chk("unl_valid", out_valid_o, ev);
      chk("unl_re", mem_re_o, er);
      if (er) chk("unl_raddr", mem_raddr_o, rd);
      if (ev && out_ready_i) begin
        chk("unl_data", ram_q, hs);
        hs++;
      end
      if (er) begin
        rd++;
        ev = 1'b1;
      end else if (ev && out_ready_i) begin
        ev = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    out_ready_i = 1'b0;
    chk("unl_count", hs, N);
    #1;
    chk("done_pulse", done_o, 1);
    chk("done_idle", busy_o, 0);
    chk("done_valid_low", out_valid_o, 0);
    @(negedge clk_i);
    chk("done_one_cycle", done_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
`ifdef FFT_INV_EN
    inv_i = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    #1;
    check_quiet("reset");
    chk("reset_waddr", mem_waddr_o, 0);
    chk("reset_b", bf_addr_b_o, 0);
    chk("reset_tw", tw_idx_o, 0);
    chk("reset_raddr", mem_raddr_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_no_start", busy_o, 0);

    run_frame(1'b1, 1'b1, -1);
    run_frame(1'b0, 1'b0, -1);
    run_frame(1'b0, 1'b0, 8);
    run_frame(1'b0, 1'b1, -1);
    for (int f = 0; f < 3; f++) run_frame(1'b0, f[0], -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
